// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - round-robin AHB bus arbiter with burst/lock tracking (optional split masking via AHB_ARB_SPLIT_EN)
module ahb_arbiter #(
    parameter int NUM_MST = 4,
    parameter int DEF_MST = 0,
    parameter int MW      = $clog2(NUM_MST)
) (
    input  logic               hclk,
    input  logic               hreset,
    input  logic [NUM_MST-1:0] hbusreq,
    input  logic [NUM_MST-1:0] hlock,
    input  logic [1:0]         htrans,
    input  logic [2:0]         hburst,
    input  logic               hready,
    input  logic [1:0]         hresp,
`ifdef AHB_ARB_SPLIT_EN
    input  logic [NUM_MST-1:0] hsplit,
`endif
    output logic [NUM_MST-1:0] hgrant,
    output logic [MW-1:0]      hmaster,
    output logic               hmastlock
);

    localparam logic [1:0] TRANS_IDLE   = 2'd0;
    localparam logic [1:0] TRANS_BUSY   = 2'd1;
    localparam logic [1:0] TRANS_NONSEQ = 2'd2;
    localparam logic [1:0] TRANS_SEQ    = 2'd3;

    localparam logic [1:0] RESP_OKAY    = 2'd0;
`ifdef AHB_ARB_SPLIT_EN
    localparam logic [1:0] RESP_SPLIT   = 2'd3;
`endif

    localparam logic [MW-1:0]      DEF_IDX   = MW'(DEF_MST);
    localparam logic [NUM_MST-1:0] GRANT_ONE = {{(NUM_MST-1){1'b0}}, 1'b1};
    localparam logic [NUM_MST-1:0] DEF_GRANT = GRANT_ONE << DEF_MST;

    logic [NUM_MST-1:0] r_hgrant;
    logic [MW-1:0]      r_hmaster;
    logic               r_hmastlock;
    logic [MW-1:0]      r_gidx;
    logic [3:0]         r_rem;

    logic [3:0]         w_len_m1;
    logic [3:0]         w_rem_nxt;
    logic               w_locked;
    logic               w_open;
    logic [NUM_MST-1:0] w_elig;
    logic [MW-1:0]      w_win;
    logic [MW-1:0]      w_k;

    // Beats remaining after a NONSEQ, decoded from the burst type
    always_comb begin
        w_len_m1 = 4'd0;
        case (hburst)
            3'd2, 3'd3: w_len_m1 = 4'd3;
            3'd4, 3'd5: w_len_m1 = 4'd7;
            3'd6, 3'd7: w_len_m1 = 4'd15;
            default:    w_len_m1 = 4'd0;
        endcase
    end

    // Next beat-counter value; a non-OKAY response terminates the burst even mid-wait
    always_comb begin
        w_rem_nxt = r_rem;
        if (hresp != RESP_OKAY) begin
            w_rem_nxt = 4'd0;
        end else if (hready) begin
            case (htrans)
                TRANS_IDLE:   w_rem_nxt = 4'd0;
                TRANS_BUSY:   w_rem_nxt = r_rem;
                TRANS_NONSEQ: w_rem_nxt = w_len_m1;
                TRANS_SEQ:    w_rem_nxt = (r_rem != 4'd0) ? r_rem - 4'd1 : r_rem;
                default:      w_rem_nxt = r_rem;
            endcase
        end
    end

    assign w_locked = hlock[r_gidx];
    assign w_open   = hready && (w_rem_nxt == 4'd0) && !w_locked;

`ifdef AHB_ARB_SPLIT_EN
    logic [NUM_MST-1:0] r_mask;
    logic [NUM_MST-1:0] w_split_set;

    // A SPLIT response parks the current address-phase owner
    always_comb begin
        w_split_set = '0;
        if (hresp == RESP_SPLIT) begin
            w_split_set[r_hmaster] = 1'b1;
        end
    end

    assign w_elig = hbusreq & ~(r_mask | w_split_set);

    // Split mask: set by SPLIT, cleared by the slave's resume pulse
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_mask <= '0;
        end else begin
            r_mask <= (r_mask | w_split_set) & ~hsplit;
        end
    end
`else
    assign w_elig = hbusreq;
`endif

    // Round-robin scan from g+1 wrapping back to g; lowest offset wins, default master if none
    always_comb begin
        w_win = DEF_IDX;
        w_k   = '0;
        for (int i = NUM_MST; i >= 1; i--) begin
            w_k = MW'((int'(r_gidx) + i) % NUM_MST);
            if (w_elig[w_k]) begin
                w_win = w_k;
            end
        end
    end

    // Grant, owner and beat-counter registers
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_rem       <= 4'd0;
            r_gidx      <= DEF_IDX;
            r_hgrant    <= DEF_GRANT;
            r_hmaster   <= DEF_IDX;
            r_hmastlock <= 1'b0;
        end else begin
            r_rem <= w_rem_nxt;
            if (w_open) begin
                r_gidx   <= w_win;
                r_hgrant <= GRANT_ONE << w_win;
            end
            if (hready) begin
                r_hmaster   <= r_gidx;
                r_hmastlock <= w_locked;
            end
        end
    end

    assign hgrant    = r_hgrant;
    assign hmaster   = r_hmaster;
    assign hmastlock = r_hmastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - scoreboard testbench for ahb_arbiter (NUM_MST=4, DEF_MST=0)
module tb_ahb_arbiter;

    localparam logic [1:0] T_IDLE = 2'd0, T_NSEQ = 2'd2, T_SEQ = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR4 = 3'd3, B_INCR8 = 3'd5, B_INCR16 = 3'd7;
    localparam logic [1:0] R_OKAY = 2'd0, R_ERROR = 2'd1, R_RETRY = 2'd2, R_SPLIT = 2'd3;

    logic       hclk = 1'b0;
    logic       hreset = 1'b0;
    logic [3:0] hbusreq = 4'b0;
    logic [3:0] hlock = 4'b0;
    logic [1:0] htrans = T_IDLE;
    logic [2:0] hburst = B_SINGLE;
    logic       hready = 1'b1;
    logic [1:0] hresp = R_OKAY;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;
`ifdef AHB_ARB_SPLIT_EN
    logic [3:0] hsplit = 4'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] tr;
        logic [2:0] bu;
        logic       rdy;
        logic [1:0] rsp;
        logic [3:0] spl;
        logic [3:0] eg;
        logic [1:0] em;
        logic       el;
    } row_t;

    typedef struct {
        string      tag;
        int         idx;
        logic [3:0] g;
        logic [1:0] m;
        logic       l;
    } exp_t;

    row_t rows[$];
    exp_t exp_q[$];

    ahb_arbiter #(.NUM_MST(4), .DEF_MST(0)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hresp     (hresp),
`ifdef AHB_ARB_SPLIT_EN
        .hsplit    (hsplit),
`endif
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic add(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy, input logic [1:0] rsp,
                       input logic [3:0] spl, input logic [3:0] eg, input logic [1:0] em,
                       input logic el);
        row_t r;
        r.req = req; r.lock = lock; r.tr = tr; r.bu = bu; r.rdy = rdy;
        r.rsp = rsp; r.spl = spl; r.eg = eg; r.em = em; r.el = el;
        rows.push_back(r);
    endtask

    function automatic exp_t mk_exp(input string tag, input int idx, input row_t r);
        exp_t x;
        x.tag = tag; x.idx = idx; x.g = r.eg; x.m = r.em; x.l = r.el;
        return x;
    endfunction

    task automatic drv(input row_t r);
        hbusreq = r.req;
        hlock   = r.lock;
        htrans  = r.tr;
        hburst  = r.bu;
        hready  = r.rdy;
        hresp   = r.rsp;
`ifdef AHB_ARB_SPLIT_EN
        hsplit  = r.spl;
`endif
    endtask

    task automatic drv_idle();
        hbusreq = 4'b0; hlock = 4'b0; htrans = T_IDLE; hburst = B_SINGLE;
        hready = 1'b1; hresp = R_OKAY;
`ifdef AHB_ARB_SPLIT_EN
        hsplit = 4'b0;
`endif
    endtask

    task automatic do_reset();
        drv_idle();
        hreset = 1'b1;
        @(posedge hclk);
        @(negedge hclk);
        hreset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        drv_idle();
        #1 hreset = 1'b1;
        #1;
        checks++;
        if ({hgrant, hmaster, hmastlock} !== {4'b0001, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: hgrant=%b hmaster=%0d hmastlock=%b, expected 0001 0 0", hgrant, hmaster, hmastlock);
        end
        @(posedge hclk);
        @(negedge hclk);
        hreset = 1'b0;
        rows.delete();
        for (int k = 0; k < 3; k++) add(4'b0000, 4'b0, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0001, 2'd0, 1'b0);
        foreach (rows[i]) begin
            drv(rows[i]);
            exp_q.push_back(mk_exp("idle_default", i, rows[i]));
            @(posedge hclk);
            @(negedge hclk);
            e = exp_q.pop_front();
            checks++;
            if ({hgrant, hmaster, hmastlock} !== {e.g, e.m, e.l}) begin
                errors++;
                $display("FAIL %s row %0d: hgrant=%b hmaster=%0d hmastlock=%b, expected %b %0d %b", e.tag, e.idx, hgrant, hmaster, hmastlock, e.g, e.m, e.l);
            end
        end
    endtask

    task automatic test_rotation();
        exp_t e;
        do_reset();
        rows.delete();
        add(4'b1110, 4'b0, T_NSEQ, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0010, 2'd0, 1'b0);
        add(4'b1110, 4'b0, T_NSEQ, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0100, 2'd1, 1'b0);
        add(4'b1110, 4'b0, T_NSEQ, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b1000, 2'd2, 1'b0);
        add(4'b1110, 4'b0, T_NSEQ, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0010, 2'd3, 1'b0);
        add(4'b1110, 4'b0, T_NSEQ, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0100, 2'd1, 1'b0);
        foreach (rows[i]) begin
            drv(rows[i]);
            exp_q.push_back(mk_exp("rotation", i, rows[i]));
            @(posedge hclk);
            @(negedge hclk);
            e = exp_q.pop_front();
            checks++;
            if ({hgrant, hmaster, hmastlock} !== {e.g, e.m, e.l}) begin
                errors++;
                $display("FAIL %s row %0d: hgrant=%b hmaster=%0d hmastlock=%b, expected %b %0d %b", e.tag, e.idx, hgrant, hmaster, hmastlock, e.g, e.m, e.l);
            end
        end
    endtask

    task automatic test_incr8_burst();
        exp_t e;
        do_reset();
        rows.delete();
        add(4'b0010, 4'b0, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0010, 2'd0, 1'b0);
        add(4'b0010, 4'b0, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0010, 2'd1, 1'b0);
        add(4'b0110, 4'b0, T_NSEQ, B_INCR8, 1'b1, R_OKAY, 4'b0, 4'b0010, 2'd1, 1'b0);
        for (int k = 0; k < 6; k++) add(4'b0110, 4'b0, T_SEQ, B_INCR8, 1'b1, R_OKAY, 4'b0, 4'b0010, 2'd1, 1'b0);
        for (int k = 0; k < 2; k++) add(4'b0110, 4'b0, T_SEQ, B_INCR8, 1'b0, R_OKAY, 4'b0, 4'b0010, 2'd1, 1'b0);
        add(4'b0100, 4'b0, T_SEQ, B_INCR8, 1'b1, R_OKAY, 4'b0, 4'b0100, 2'd1, 1'b0);
        add(4'b0100, 4'b0, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0100, 2'd2, 1'b0);
        foreach (rows[i]) begin
            drv(rows[i]);
            exp_q.push_back(mk_exp("incr8_burst", i, rows[i]));
            @(posedge hclk);
            @(negedge hclk);
            e = exp_q.pop_front();
            checks++;
            if ({hgrant, hmaster, hmastlock} !== {e.g, e.m, e.l}) begin
                errors++;
                $display("FAIL %s row %0d: hgrant=%b hmaster=%0d hmastlock=%b, expected %b %0d %b", e.tag, e.idx, hgrant, hmaster, hmastlock, e.g, e.m, e.l);
            end
        end
    endtask

    task automatic test_lock();
        exp_t e;
        do_reset();
        rows.delete();
        add(4'b1000, 4'b1000, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b1000, 2'd0, 1'b0);
        add(4'b1001, 4'b1000, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b1000, 2'd3, 1'b1);
        for (int b = 0; b < 2; b++) begin
            add(4'b1001, 4'b1000, T_NSEQ, B_INCR4, 1'b1, R_OKAY, 4'b0, 4'b1000, 2'd3, 1'b1);
            for (int k = 0; k < 3; k++) add(4'b1001, 4'b1000, T_SEQ, B_INCR4, 1'b1, R_OKAY, 4'b0, 4'b1000, 2'd3, 1'b1);
        end
        add(4'b1001, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0001, 2'd3, 1'b0);
        add(4'b0001, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0001, 2'd0, 1'b0);
        foreach (rows[i]) begin
            drv(rows[i]);
            exp_q.push_back(mk_exp("lock", i, rows[i]));
            @(posedge hclk);
            @(negedge hclk);
            e = exp_q.pop_front();
            checks++;
            if ({hgrant, hmaster, hmastlock} !== {e.g, e.m, e.l}) begin
                errors++;
                $display("FAIL %s row %0d: hgrant=%b hmaster=%0d hmastlock=%b, expected %b %0d %b", e.tag, e.idx, hgrant, hmaster, hmastlock, e.g, e.m, e.l);
            end
        end
    endtask

    task automatic test_error_response();
        exp_t e;
        do_reset();
        rows.delete();
        add(4'b0010, 4'b0, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0010, 2'd0, 1'b0);
        add(4'b0010, 4'b0, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0010, 2'd1, 1'b0);
        add(4'b0110, 4'b0, T_NSEQ, B_INCR16, 1'b1, R_OKAY, 4'b0, 4'b0010, 2'd1, 1'b0);
        add(4'b0110, 4'b0, T_SEQ, B_INCR16, 1'b0, R_ERROR, 4'b0, 4'b0010, 2'd1, 1'b0);
        add(4'b0110, 4'b0, T_SEQ, B_INCR16, 1'b1, R_OKAY, 4'b0, 4'b0100, 2'd1, 1'b0);
        add(4'b0100, 4'b0, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0100, 2'd2, 1'b0);
        add(4'b0110, 4'b0, T_NSEQ, B_INCR4, 1'b1, R_RETRY, 4'b0, 4'b0010, 2'd2, 1'b0);
        foreach (rows[i]) begin
            drv(rows[i]);
            exp_q.push_back(mk_exp("error_resp", i, rows[i]));
            @(posedge hclk);
            @(negedge hclk);
            e = exp_q.pop_front();
            checks++;
            if ({hgrant, hmaster, hmastlock} !== {e.g, e.m, e.l}) begin
                errors++;
                $display("FAIL %s row %0d: hgrant=%b hmaster=%0d hmastlock=%b, expected %b %0d %b", e.tag, e.idx, hgrant, hmaster, hmastlock, e.g, e.m, e.l);
            end
        end
    endtask

    task automatic test_split();
        exp_t e;
        do_reset();
        rows.delete();
        add(4'b0100, 4'b0, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0100, 2'd0, 1'b0);
        add(4'b0100, 4'b0, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0100, 2'd2, 1'b0);
        add(4'b0100, 4'b0, T_NSEQ, B_INCR4, 1'b1, R_OKAY, 4'b0, 4'b0100, 2'd2, 1'b0);
        add(4'b0100, 4'b0, T_SEQ, B_INCR4, 1'b0, R_SPLIT, 4'b0, 4'b0100, 2'd2, 1'b0);
`ifdef AHB_ARB_SPLIT_EN
        add(4'b0100, 4'b0, T_IDLE, B_SINGLE, 1'b1, R_SPLIT, 4'b0, 4'b0001, 2'd2, 1'b0);
        add(4'b0100, 4'b0, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0001, 2'd0, 1'b0);
        add(4'b0000, 4'b0, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0100, 4'b0001, 2'd0, 1'b0);
`else
        add(4'b0100, 4'b0, T_IDLE, B_SINGLE, 1'b1, R_SPLIT, 4'b0, 4'b0100, 2'd2, 1'b0);
        add(4'b0100, 4'b0, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0100, 2'd2, 1'b0);
        add(4'b0000, 4'b0, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0100, 4'b0001, 2'd2, 1'b0);
`endif
        add(4'b0100, 4'b0, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0100, 2'd0, 1'b0);
        add(4'b0100, 4'b0, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0100, 2'd2, 1'b0);
        foreach (rows[i]) begin
            drv(rows[i]);
            exp_q.push_back(mk_exp("split", i, rows[i]));
            @(posedge hclk);
            @(negedge hclk);
            e = exp_q.pop_front();
            checks++;
            if ({hgrant, hmaster, hmastlock} !== {e.g, e.m, e.l}) begin
                errors++;
                $display("FAIL %s row %0d: hgrant=%b hmaster=%0d hmastlock=%b, expected %b %0d %b", e.tag, e.idx, hgrant, hmaster, hmastlock, e.g, e.m, e.l);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        do_reset();
        rows.delete();
        add(4'b0010, 4'b0010, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0010, 2'd0, 1'b0);
        add(4'b0010, 4'b0010, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0010, 2'd1, 1'b1);
        add(4'b0010, 4'b0010, T_NSEQ, B_INCR8, 1'b1, R_OKAY, 4'b0, 4'b0010, 2'd1, 1'b1);
        add(4'b0010, 4'b0010, T_SEQ, B_INCR8, 1'b1, R_OKAY, 4'b0, 4'b0010, 2'd1, 1'b1);
        foreach (rows[i]) begin
            drv(rows[i]);
            exp_q.push_back(mk_exp("pre_reset", i, rows[i]));
            @(posedge hclk);
            @(negedge hclk);
            e = exp_q.pop_front();
            checks++;
            if ({hgrant, hmaster, hmastlock} !== {e.g, e.m, e.l}) begin
                errors++;
                $display("FAIL %s row %0d: hgrant=%b hmaster=%0d hmastlock=%b, expected %b %0d %b", e.tag, e.idx, hgrant, hmaster, hmastlock, e.g, e.m, e.l);
            end
        end
        #2 hreset = 1'b1;
        #1;
        checks++;
        if ({hgrant, hmaster, hmastlock} !== {4'b0001, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: hgrant=%b hmaster=%0d hmastlock=%b, expected 0001 0 0", hgrant, hmaster, hmastlock);
        end
        @(posedge hclk);
        @(negedge hclk);
        hreset = 1'b0;
        rows.delete();
        add(4'b0100, 4'b0000, T_SEQ, B_INCR8, 1'b1, R_OKAY, 4'b0, 4'b0100, 2'd0, 1'b0);
        add(4'b0100, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 4'b0, 4'b0100, 2'd2, 1'b0);
        foreach (rows[i]) begin
            drv(rows[i]);
            exp_q.push_back(mk_exp("post_reset", i, rows[i]));
            @(posedge hclk);
            @(negedge hclk);
            e = exp_q.pop_front();
            checks++;
            if ({hgrant, hmaster, hmastlock} !== {e.g, e.m, e.l}) begin
                errors++;
                $display("FAIL %s row %0d: hgrant=%b hmaster=%0d hmastlock=%b, expected %b %0d %b", e.tag, e.idx, hgrant, hmaster, hmastlock, e.g, e.m, e.l);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_incr8_burst();
        test_lock();
        test_error_response();
        test_split();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin AHB bus arbiter sharing one AHB bus between `NUM_MST` masters. Samples per-master `hbusreq`/`hlock`, tracks the current owner's burst progress from the shared `htrans`/`hburst`/`hready`/`hresp`, and drives one-hot `hgrant`, the registered `hmaster` index and `hmastlock`. Sits between the master agents' interfaces and the address/data mux that the `hmaster` output steers.

## Interface
- `NUM_MST`, 4: number of masters, 2..16.
- `DEF_MST`, 0: default master, granted when nobody requests.
- `MW`, `$clog2(NUM_MST)`: width of `hmaster` (derived).

- `hclk`  in  1  bus clock, all state on rising edge.
- `hreset`  in  1  asynchronous, active-high reset.
- `hbusreq`  in  NUM_MST  per-master bus request.
- `hlock`  in  NUM_MST  per-master locked-access request.
- `htrans`  in  2  shared bus transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hburst`  in  3  shared bus burst type: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- `hready`  in  1  shared bus ready.
- `hresp`  in  2  shared bus response: OKAY=0, ERROR=1, RETRY=2, SPLIT=3.
- `hsplit`  in  NUM_MST  split-resume pulses; present only with the macro.
- `hgrant`  out  NUM_MST  one-hot grant, registered.
- `hmaster`  out  MW  address-phase owner index, registered.
- `hmastlock`  out  1  current transfer is locked, registered.

## Operation
- **Reset values:**
  - `hgrant` = one-hot(`DEF_MST`).
  - `hmaster` = `DEF_MST`.
  - `hmastlock` = 0.
  - Beat counter `rem` = 0.
  - Round-robin pointer = `DEF_MST`.
- **Beat counter**, updated only on edges with `hready`=1:
  - NONSEQ: `rem` ← len−1, where len = 4/8/16 for WRAP4/INCR4, WRAP8/INCR8, WRAP16/INCR16, and len = 1 for SINGLE/INCR.
  - SEQ with `rem`>0: `rem` ← `rem`−1.
  - IDLE: `rem` ← 0.
  - BUSY: `rem` unchanged.
  - Any `hresp`≠OKAY, regardless of `hready`: `rem` ← 0 (burst terminated).
- **Arbitration-open condition:** `hready`=1, next-`rem`=0, and not locked.
  - Locked means `hlock[g]`=1, where g is the currently granted index.
  - Undefined-length INCR is therefore re-arbitrable on every ready cycle.
- **Grant selection** (evaluated when arbitration is open):
  - Scan requesters starting at g+1 and wrapping modulo `NUM_MST`; the first with `hbusreq`=1 wins.
  - If g itself is the only requester, g keeps the grant.
  - If no requests, grant `DEF_MST`.
  - The new `hgrant` is registered at that edge.
- **Owner tracking:** on every edge with `hready`=1, `hmaster` ← index(`hgrant`) and `hmastlock` ← `hlock[index(hgrant)]`.
- **Invariant:** `hgrant` is always exactly one-hot, including the no-request case.
- **Simultaneous events:** an ERROR/RETRY response in the same cycle as a NONSEQ clears `rem` (the response wins).

## Timing
- Request to `hgrant`: 1 edge when arbitration is open.
- `hgrant` to `hmaster`: next edge with `hready`=1. Stalled `hready` holds `hmaster` and `hgrant` stable.
- Fixed burst: grant may move at the edge that accepts the last beat's address. Example: INCR4 moves at the 4th address-phase accept, never earlier.
- Lock: grant is held while the owner's `hlock`=1. Release occurs at the first open cycle after `hlock` drops.
- Reset asserted mid-burst: all outputs return to reset values asynchronously. The burst is forgotten; no recovery state is kept.

## Configuration
- Macro `AHB_ARB_SPLIT_EN`.
- **Defined:**
  - `hsplit` port exists.
  - A SPLIT response sets `mask[hmaster]`.
  - Masked masters are excluded from arbitration; `DEF_MST` is chosen if all requesters are masked.
  - `hsplit[i]`=1 clears `mask[i]` on the next edge.
  - `mask` resets to 0.
- **Undefined:**
  - No `hsplit` port and no mask.
  - SPLIT behaves exactly as RETRY: burst terminated, master stays eligible.

## Test plan
- Reset with `hbusreq`=0 → `hgrant`=4'b0001, `hmaster`=0, `hmastlock`=0. Grant stays there with no requests.
- Masters 1, 2, 3 request continuously with SINGLE transfers, `hready`=1 → grant rotates 1→2→3→1. `hmaster` lags `hgrant` by one cycle.
- Master 1 issues INCR8 while master 2 requests → `hgrant` stays 0010 through 7 SEQ beats. It moves to 0100 at the edge accepting beat 8. Inserting 2 wait states (`hready`=0) delays the move by 2 cycles.
- Master 3 holds `hlock`=1 across two INCR4 bursts while master 0 requests → no grant change until `hlock` drops; then master 0 is granted next open cycle and `hmastlock` clears.
- ERROR response on beat 2 of master 1's INCR16 with master 2 requesting → `rem`=0 and grant moves to master 2 at the next `hready`=1 edge.
- With `AHB_ARB_SPLIT_EN`:
  - SPLIT to master 2 → master 2 is skipped while requesting.
  - `hsplit[2]` pulse → master 2 is re-granted in round-robin order.
  - Without the macro, the same stimulus re-grants master 2 normally.
